// File: rtl/box_slot_manager_if.sv
// Box offer port between the detector (master) and the slot manager (slave).
// Handshake: a box transfers on every pixelclk rising edge where box_valid && box_ready;
// box_ready never depends on box_valid, and the detector holds the box fields stable while box_valid is high.
interface box_slot_manager_if #(
  parameter int CW = 12
) ();
  logic          box_valid;
  logic          box_ready;
  logic [CW-1:0] box_hl;
  logic [CW-1:0] box_hr;
  logic [CW-1:0] box_vt;
  logic [CW-1:0] box_vb;

  modport master (
    output box_valid, box_hl, box_hr, box_vt, box_vb,
    input  box_ready
  );

  modport slave (
    input  box_valid, box_hl, box_hr, box_vt, box_vb,
    output box_ready
  );
endinterface

// File: rtl/box_slot_manager.sv
// Frame-synchronous slot scheduler: boxes collect into a shadow table during a frame
// and the whole table is swapped into the active overlay table one cycle after the vsync edge.
module box_slot_manager #(
  parameter int NUM_BOXES   = 8,
  parameter int CW          = 12,
  parameter int HOLD_FRAMES = 3,
  parameter bit VS_POL      = 1'b1
) (
  input  logic                    pixelclk,
  input  logic                    reset,
  input  logic                    i_vsync,
  box_slot_manager_if.slave       det,
  output logic [NUM_BOXES-1:0]    slot_en,
  output logic [NUM_BOXES*CW-1:0] slot_hl,
  output logic [NUM_BOXES*CW-1:0] slot_hr,
  output logic [NUM_BOXES*CW-1:0] slot_vt,
  output logic [NUM_BOXES*CW-1:0] slot_vb,
  output logic [3:0]              frame_cnt,
  output logic                    overflow,
  output logic [7:0]              reject_cnt,
  output logic                    state_dbg
);

  localparam int            HW       = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);
  localparam logic [3:0]    CNT_MAX  = 4'(NUM_BOXES);

  typedef enum logic {
    COLLECT = 1'b0,
    SWAP    = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 vsync_d;
  logic                 frame_edge;
  logic                 box_ready_c;
  logic                 xfer;
  logic                 legal;
  logic [3:0]           sh_cnt;
  logic                 sh_ovf;
  logic [7:0]           sh_rej;
  logic [HW-1:0]        hold;
  logic [NUM_BOXES-1:0] en_mask;

  logic [CW-1:0] sh_hl  [NUM_BOXES];
  logic [CW-1:0] sh_hr  [NUM_BOXES];
  logic [CW-1:0] sh_vt  [NUM_BOXES];
  logic [CW-1:0] sh_vb  [NUM_BOXES];
  logic [CW-1:0] act_hl [NUM_BOXES];
  logic [CW-1:0] act_hr [NUM_BOXES];
  logic [CW-1:0] act_vt [NUM_BOXES];
  logic [CW-1:0] act_vb [NUM_BOXES];

  assign frame_edge    = (i_vsync == VS_POL) && (vsync_d != VS_POL);
  assign legal         = (det.box_hl < det.box_hr) && (det.box_vt < det.box_vb);
  assign xfer          = det.box_valid && box_ready_c;
  assign det.box_ready = box_ready_c;
  assign state_dbg     = (state == SWAP);

  always_comb begin
    state_nxt   = state;
    box_ready_c = 1'b0;
    case (state)
      COLLECT: begin
        box_ready_c = 1'b1;
        if (frame_edge) state_nxt = SWAP;
      end
      SWAP:    state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Thermometer of the stored entry count: the enables a non-empty swap installs.
  always_comb begin
    en_mask = '0;
    for (int i = 0; i < NUM_BOXES; i++) begin
      en_mask[i] = (4'(i) < sh_cnt);
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state      <= COLLECT;
      vsync_d    <= 1'b0;
      sh_cnt     <= '0;
      sh_ovf     <= 1'b0;
      sh_rej     <= '0;
      hold       <= '0;
      slot_en    <= '0;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
      reject_cnt <= '0;
    end else begin
      state   <= state_nxt;
      vsync_d <= i_vsync;
      if (state == SWAP) begin
        frame_cnt  <= sh_cnt;
        overflow   <= sh_ovf;
        reject_cnt <= sh_rej;
        sh_cnt     <= '0;
        sh_ovf     <= 1'b0;
        sh_rej     <= '0;
        // An empty frame keeps the previous boxes for up to HOLD_FRAMES swaps.
        if (sh_cnt != 4'd0) begin
          slot_en <= en_mask;
          hold    <= '0;
        end else if (hold < HOLD_MAX) begin
          hold <= hold + HW'(1);
        end else begin
          slot_en <= '0;
        end
      end else if (xfer) begin
        if (!legal) begin
          if (sh_rej != 8'hFF) sh_rej <= sh_rej + 8'd1;
        end else if (sh_cnt < CNT_MAX) begin
          sh_cnt <= sh_cnt + 4'd1;
        end else begin
          sh_ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        sh_hl[i] <= '0;
        sh_hr[i] <= '0;
        sh_vt[i] <= '0;
        sh_vb[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        if (xfer && legal && (sh_cnt == 4'(i))) begin
          sh_hl[i] <= det.box_hl;
          sh_hr[i] <= det.box_hr;
          sh_vt[i] <= det.box_vt;
          sh_vb[i] <= det.box_vb;
        end
      end
    end
  end

  // The whole shadow table is copied; slots at or above the count are masked by slot_en.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        act_hl[i] <= '0;
        act_hr[i] <= '0;
        act_vt[i] <= '0;
        act_vb[i] <= '0;
      end
    end else if ((state == SWAP) && (sh_cnt != 4'd0)) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        act_hl[i] <= sh_hl[i];
        act_hr[i] <= sh_hr[i];
        act_vt[i] <= sh_vt[i];
        act_vb[i] <= sh_vb[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_BOXES; g++) begin : g_pack
    assign slot_hl[g*CW +: CW] = act_hl[g];
    assign slot_hr[g*CW +: CW] = act_hr[g];
    assign slot_vt[g*CW +: CW] = act_vt[g];
    assign slot_vb[g*CW +: CW] = act_vb[g];
  end

endmodule

// File: tb/tb_box_slot_manager.sv
// Directed bench for box_slot_manager: a small frame model pushes the expected swap
// results into queues as boxes are driven, and each swap pops and compares them.
module tb_box_slot_manager;
  localparam int NB   = 8;
  localparam int CW   = 12;
  localparam int HOLD = 3;

  logic           pixelclk = 1'b0;
  logic           reset;
  logic           i_vsync;
  logic [NB-1:0]  slot_en;
  logic [NB*CW-1:0] slot_hl, slot_hr, slot_vt, slot_vb;
  logic [3:0]     frame_cnt;
  logic           overflow;
  logic [7:0]     reject_cnt;
  logic           state_dbg;

  box_slot_manager_if #(.CW(CW)) det_if ();

  box_slot_manager #(
    .NUM_BOXES(NB), .CW(CW), .HOLD_FRAMES(HOLD), .VS_POL(1'b1)
  ) dut (
    .pixelclk  (pixelclk),
    .reset     (reset),
    .i_vsync   (i_vsync),
    .det       (det_if),
    .slot_en   (slot_en),
    .slot_hl   (slot_hl),
    .slot_hr   (slot_hr),
    .slot_vt   (slot_vt),
    .slot_vb   (slot_vb),
    .frame_cnt (frame_cnt),
    .overflow  (overflow),
    .reject_cnt(reject_cnt),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 pixelclk = ~pixelclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: {slot_en, frame_cnt, overflow, reject_cnt} per swap, bounds per enabled slot
  logic [20:0]     exp_q[$];
  logic [4*CW-1:0] bnd_q[$];

  // frame model
  logic [4*CW-1:0] m_sh  [NB];
  logic [4*CW-1:0] m_act [NB];
  logic [NB-1:0]   m_en;
  int              m_cnt, m_rej, m_hold;
  logic            m_ovf;

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_cnt = 0; m_rej = 0; m_hold = 0; m_ovf = 1'b0;
    for (int i = 0; i < NB; i++) begin
      m_sh[i] = '0;
      m_act[i] = '0;
    end
  endtask

  task automatic model_add(input logic [CW-1:0] hl, hr, vt, vb);
    if (!(hl < hr && vt < vb)) begin
      if (m_rej < 255) m_rej++;
    end else if (m_cnt < NB) begin
      m_sh[m_cnt] = {hl, hr, vt, vb};
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_frame();
    if (m_cnt > 0) begin
      for (int i = 0; i < m_cnt; i++) m_act[i] = m_sh[i];
      m_en = NB'((1 << m_cnt) - 1);
      m_hold = 0;
    end else if (m_hold < HOLD) begin
      m_hold++;
    end else begin
      m_en = '0;
    end
    exp_q.push_back({m_en, 4'(m_cnt), m_ovf, 8'(m_rej)});
    for (int i = 0; i < NB; i++) if (m_en[i]) bnd_q.push_back(m_act[i]);
    m_cnt = 0; m_rej = 0; m_ovf = 1'b0;
  endtask

  task automatic check_swap(input string tag);
    logic [20:0]     e;
    logic [NB-1:0]   een;
    logic [4*CW-1:0] b;
    check({tag, "_qsz"}, 64'(exp_q.size() > 0), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      een = e[20:13];
      check({tag, "_en"},   64'(slot_en),    64'(een));
      check({tag, "_fcnt"}, 64'(frame_cnt),  64'(e[12:9]));
      check({tag, "_ovf"},  64'(overflow),   64'(e[8]));
      check({tag, "_rej"},  64'(reject_cnt), 64'(e[7:0]));
      for (int i = 0; i < NB; i++) begin
        if (een[i] && bnd_q.size() > 0) begin
          b = bnd_q.pop_front();
          check({tag, "_bnd"},
                64'({slot_hl[i*CW +: CW], slot_hr[i*CW +: CW], slot_vt[i*CW +: CW], slot_vb[i*CW +: CW]}),
                64'(b));
        end
      end
    end
  endtask

  // driver: offer one box, wait (bounded) for acceptance
  task automatic send_box(input logic [CW-1:0] hl, hr, vt, vb);
    bit done = 1'b0;
    det_if.box_valid = 1'b1;
    det_if.box_hl = hl; det_if.box_hr = hr; det_if.box_vt = vt; det_if.box_vb = vb;
    for (int k = 0; k < 4 && !done; k++) begin
      if (det_if.box_ready === 1'b1) begin
        model_add(hl, hr, vt, vb);
        done = 1'b1;
      end
      tick();
    end
    det_if.box_valid = 1'b0;
    check("send_accept", 64'(done), 64'(1));
  endtask

  task automatic send_rand(input bit degenerate);
    logic [CW-1:0] hl, hr, vt, vb;
    hl = 12'($urandom_range(0, 1500));
    vt = 12'($urandom_range(0, 900));
    hr = hl + 12'($urandom_range(1, 300));
    vb = vt + 12'($urandom_range(1, 150));
    if (degenerate) begin
      if ($urandom_range(0, 1) == 0) hr = hl;
      else vb = vt - 12'($urandom_range(0, 5));
    end
    send_box(hl, hr, vt, vb);
  endtask

  task automatic end_frame(input string tag);
    i_vsync = 1'b1;
    tick();
    check({tag, "_swap_ready"}, 64'(det_if.box_ready), 64'(0));
    check({tag, "_swap_state"}, 64'(state_dbg), 64'(1));
    model_frame();
    tick();
    check_swap(tag);
    i_vsync = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int nbox;
    reset = 1'b1;
    i_vsync = 1'b0;
    det_if.box_valid = 1'b0;
    det_if.box_hl = '0; det_if.box_hr = '0; det_if.box_vt = '0; det_if.box_vb = '0;
    model_reset();

    // T1 reset
    repeat (3) tick();
    reset = 1'b0;
    check("t1_ready", 64'(det_if.box_ready), 64'(1));
    check("t1_en",    64'(slot_en),    64'(0));
    check("t1_fcnt",  64'(frame_cnt),  64'(0));
    check("t1_ovf",   64'(overflow),   64'(0));
    check("t1_rej",   64'(reject_cnt), 64'(0));
    check("t1_state", 64'(state_dbg),  64'(0));
    tick();

    // T2 basic swap
    send_box(12'd10,  12'd50,  12'd20, 12'd60);
    send_box(12'd100, 12'd140, 12'd20, 12'd60);
    send_box(12'd200, 12'd260, 12'd30, 12'd90);
    end_frame("t2");
    check("t2_en_const",  64'(slot_en),          64'(8'b0000_0111));
    check("t2_hl1_const", 64'(slot_hl[CW +: CW]), 64'(100));
    check("t2_fcnt_const", 64'(frame_cnt),       64'(3));

    // T3 table full
    for (int i = 0; i < 10; i++) send_box(12'(20 * i), 12'(20 * i + 15), 12'(i), 12'(i + 40));
    end_frame("t3");
    check("t3_en_const",   64'(slot_en),   64'(8'hFF));
    check("t3_ovf_const",  64'(overflow),  64'(1));
    check("t3_fcnt_const", 64'(frame_cnt), 64'(8));

    // T4 degenerate box
    send_box(12'd50, 12'd50, 12'd10, 12'd20);
    send_box(12'd60, 12'd90, 12'd10, 12'd20);
    end_frame("t4");
    check("t4_rej_const",  64'(reject_cnt), 64'(1));
    check("t4_en_const",   64'(slot_en),    64'(8'b1));
    check("t4_fcnt_const", 64'(frame_cnt),  64'(1));

    // T5 hold over empty frames
    send_box(12'd5,  12'd25, 12'd5, 12'd25);
    send_box(12'd30, 12'd60, 12'd5, 12'd25);
    end_frame("t5_full");
    for (int f = 1; f <= 4; f++) begin
      end_frame("t5_empty");
      check("t5_en_const", 64'(slot_en), (f <= 3) ? 64'(8'b11) : 64'(0));
    end

    // random frames, mixed legal/degenerate/overflow
    for (int f = 0; f < 5; f++) begin
      nbox = $urandom_range(0, 11);
      for (int i = 0; i < nbox; i++) send_rand($urandom_range(0, 4) == 0);
      end_frame("rand");
    end

    // T6 edge-cycle and swap-cycle offers
    send_box(12'd300, 12'd340, 12'd100, 12'd150);
    i_vsync = 1'b1;
    det_if.box_valid = 1'b1;
    det_if.box_hl = 12'd400; det_if.box_hr = 12'd450; det_if.box_vt = 12'd100; det_if.box_vb = 12'd150;
    check("t6_edge_ready", 64'(det_if.box_ready), 64'(1));
    model_add(12'd400, 12'd450, 12'd100, 12'd150);
    tick();
    model_frame();
    det_if.box_hl = 12'd500; det_if.box_hr = 12'd560; det_if.box_vt = 12'd200; det_if.box_vb = 12'd220;
    check("t6_swap_ready", 64'(det_if.box_ready), 64'(0));
    tick();
    check_swap("t6a");
    check("t6a_en_const",   64'(slot_en),   64'(8'b11));
    check("t6a_fcnt_const", 64'(frame_cnt), 64'(2));
    check("t6_post_ready",  64'(det_if.box_ready), 64'(1));
    model_add(12'd500, 12'd560, 12'd200, 12'd220);
    tick();
    det_if.box_valid = 1'b0;
    i_vsync = 1'b0;
    tick();
    end_frame("t6b");
    check("t6b_en_const", 64'(slot_en),        64'(8'b1));
    check("t6b_hl0",      64'(slot_hl[0 +: CW]), 64'(500));

    // T6 reset during SWAP
    send_box(12'd10, 12'd20, 12'd10, 12'd20);
    send_box(12'd30, 12'd40, 12'd10, 12'd20);
    i_vsync = 1'b1;
    tick();
    check("t6r_state", 64'(state_dbg), 64'(1));
    reset = 1'b1;
    i_vsync = 1'b0;
    tick();
    check("t6r_en",   64'(slot_en),   64'(0));
    check("t6r_fcnt", 64'(frame_cnt), 64'(0));
    tick();
    reset = 1'b0;
    model_reset();
    check("t6r_ready", 64'(det_if.box_ready), 64'(1));
    tick();
    end_frame("t6r_empty");
    send_box(12'd70, 12'd90, 12'd40, 12'd60);
    end_frame("t6r_first");

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("bnd_q_drained", 64'(bnd_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
